rbus_eject: RTL

RBUS_EJECT -- requirements
Module: rbus_eject

---
 rtl/rbus_eject.sv | 131 +++++++++++++
 1 files changed

// File: rtl/rbus_eject.sv
// rbus_eject: ring stop that copies beats addressed to IDA/IDB into a 4-entry local eject FIFO.
// Latency: ring beat to out_* is 1 cycle; an ejected beat is visible on loc_* 1 cycle after arrival.
// Backpressure: the ring never stalls. A first beat is refused (and counted) unless 2 entries are free.
// Ports: clk/rst (sync, active-high); in_* ring beat in; out_* registered ring beat out;
//        loc_valid/loc_ready/loc_* FIFO head to the local consumer; fifo_level, bounce_cnt status.
module rbus_eject #(
  parameter logic [4:0] IDA        = 5'd0,
  parameter logic [4:0] IDB        = IDA,
  parameter int         SIG_W      = 16,
  parameter int         USED_BIT   = 0,
  parameter int         SECOND_BIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SIG_W-1:0] in_signals,
  input  logic [9:0]       in_src_req,
  input  logic [9:0]       in_dst_req,
  input  logic [36:0]      in_address,
  output logic [SIG_W-1:0] out_signals,
  output logic [9:0]       out_src_req,
  output logic [9:0]       out_dst_req,
  output logic [36:0]      out_address,
  output logic             loc_valid,
  input  logic             loc_ready,
  output logic [SIG_W-1:0] loc_signals,
  output logic [9:0]       loc_src_req,
  output logic [36:0]      loc_address,
  output logic [2:0]       fifo_level,
  output logic [15:0]      bounce_cnt
);

  localparam int         ENT_W   = SIG_W + 10 + 37;
  localparam logic [9:0] IDA_EXT = {5'd0, IDA};
  localparam logic [9:0] IDB_EXT = {5'd0, IDB};

  logic [SIG_W-1:0] out_signals_q, out_signals_d;
  logic [9:0]       out_src_req_q, out_src_req_d;
  logic [9:0]       out_dst_req_q, out_dst_req_d;
  logic [36:0]      out_address_q, out_address_d;
  logic [1:0]       wr_ptr_q, wr_ptr_d;
  logic [1:0]       rd_ptr_q, rd_ptr_d;
  logic [2:0]       level_q, level_d;
  logic             pend_second_q, pend_second_d;
  logic [15:0]      bounce_q, bounce_d;
  logic [ENT_W-1:0] mem_q [4];
  logic [ENT_W-1:0] mem_d [4];

  logic       hit, first_hit, first_eject, second_eject, push, pop;
  logic [2:0] free_ent;

  always_comb begin
    hit          = in_signals[USED_BIT] && ((in_dst_req == IDA_EXT) || (in_dst_req == IDB_EXT));
    first_hit    = hit && !in_signals[SECOND_BIT];
    // Free entries are judged before this cycle's pop; needing two keeps a slot for the partner beat.
    free_ent     = 3'd4 - level_q;
    first_eject  = first_hit && (free_ent >= 3'd2);
    second_eject = hit && in_signals[SECOND_BIT] && pend_second_q;
    push         = first_eject || second_eject;
    pop          = (level_q != 3'd0) && loc_ready;

    out_signals_d = in_signals;
    if (push) begin
      out_signals_d[USED_BIT] = 1'b0;
    end
    out_src_req_d = in_src_req;
    out_dst_req_d = in_dst_req;
    out_address_d = in_address;

    // Only the cycle right after an accepted first beat may eject a second beat.
    pend_second_d = first_eject;

    bounce_d = bounce_q;
    if (first_hit && !first_eject && (bounce_q != 16'hFFFF)) begin
      bounce_d = bounce_q + 16'd1;
    end

    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = {in_signals, in_src_req, in_address};
    end
    wr_ptr_d = push ? wr_ptr_q + 2'd1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 2'd1 : rd_ptr_q;

    case ({push, pop})
      2'b10:   level_d = level_q + 3'd1;
      2'b01:   level_d = level_q - 3'd1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_signals_q <= '0;
      out_src_req_q <= '0;
      out_dst_req_q <= '0;
      out_address_q <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      pend_second_q <= 1'b0;
      bounce_q      <= '0;
    end else begin
      out_signals_q <= out_signals_d;
      out_src_req_q <= out_src_req_d;
      out_dst_req_q <= out_dst_req_d;
      out_address_q <= out_address_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      pend_second_q <= pend_second_d;
      bounce_q      <= bounce_d;
    end
  end

  // Storage needs no reset: the pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign out_signals = out_signals_q;
  assign out_src_req = out_src_req_q;
  assign out_dst_req = out_dst_req_q;
  assign out_address = out_address_q;
  assign loc_valid   = (level_q != 3'd0);
  assign loc_signals = mem_q[rd_ptr_q][ENT_W-1 -: SIG_W];
  assign loc_src_req = mem_q[rd_ptr_q][46:37];
  assign loc_address = mem_q[rd_ptr_q][36:0];
  assign fifo_level  = level_q;
  assign bounce_cnt  = bounce_q;

endmodule
